alu_issue_arbiter: RTL and testbench

//  Shares the single EX-stage ALU datapath between two requesters: port 0 (main pipeline, IDEX) and

---
 rtl/alu_issue_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// ---------------------------------------------------------------------------
// alu_issue_arbiter
//
// Shares the single EX-stage ALU between two requesters:
//   port 0 : main pipeline (IDEX), fixed priority
//   port 1 : SIMD loop / coprocessor engine, protected by a starvation counter
//
// One op is arbitrated per cycle and registered into an issue stage. The
// issue stage drives the combinational ALU. The ALU outputs are captured into
// a response stage, which pulses rsp_valid to the port that owns the op.
//   accept at T -> ALU driven at T+1 -> rsp_valid[owner] at T+2
//
// Optional feature (compile-time macro ALU_ARB_LOCK_EN):
//   An accepted transfer with req_lock[i]=1 locks the grant to port i. The
//   lock is released by that port's next accepted transfer with req_lock[i]=0.
//   While the lock is held, the other port is never ready and the starvation
//   counter is frozen. When the macro is undefined, req_lock is ignored and no
//   lock state exists.
//
// Parameters
//   OP_W      ALU opcode width
//   DATA_W    operand / result width
//   MAX_WAIT  waiting cycles of port 1 before it preempts port 0 (1..15)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   stall                global EX stall; freezes the issue and response stages
//   req_valid[1:0]       per-port request valid
//   req_ready[1:0]       per-port accept (one-hot or zero, combinational)
//   req_lock[1:0]        per-port lock request (ALU_ARB_LOCK_EN only)
//   req{0,1}_op/s1/s2    per-port opcode and operands
//   alu_op/s1/s2         issue-stage outputs to the ALU (0 when the stage is empty)
//   alu_result           ALU data result (same cycle)
//   alu_branch_flag      ALU branch-taken flag
//   alu_ic_en            ALU recognised the op
//   rsp_valid[1:0]       one-cycle response pulse to the owning port
//   rsp_data             registered result (0 for an unrecognised op)
//   rsp_branch           registered branch flag
//   rsp_err              1 when the ALU did not recognise the op
// ---------------------------------------------------------------------------
module alu_issue_arbiter #(
   parameter int OP_W     = 5,
   parameter int DATA_W   = 64,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [1:0]        req_lock,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [DATA_W-1:0] req0_s1,
   input  logic [DATA_W-1:0] req0_s2,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req1_s1,
   input  logic [DATA_W-1:0] req1_s2,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_s1,
   output logic [DATA_W-1:0] alu_s2,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_branch_flag,
   input  logic              alu_ic_en,
   output logic [1:0]        rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_branch,
   output logic              rsp_err
);

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   logic [1:0]        grant;
   logic [3:0]        starve_cnt;

   logic              issue_valid;
   logic              issue_owner;   // 0 = port 0, 1 = port 1
   logic [OP_W-1:0]   issue_op;
   logic [DATA_W-1:0] issue_s1;
   logic [DATA_W-1:0] issue_s2;

   logic [OP_W-1:0]   sel_op;
   logic [DATA_W-1:0] sel_s1;
   logic [DATA_W-1:0] sel_s2;

   logic              lock_active;
   logic              lock_owner;

   // ------------------------------------------------------------------------
   // Optional grant lock
   // ------------------------------------------------------------------------
`ifdef ALU_ARB_LOCK_EN
   // grant is non-zero only when a transfer actually happens (it already
   // folds in stall and req_valid), so it doubles as the transfer strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_active <= 1'b0;
         lock_owner  <= 1'b0;
      end else if (|grant) begin
         if (req_lock[grant[1]]) begin
            lock_active <= 1'b1;
            lock_owner  <= grant[1];
         end else if (lock_active && (lock_owner == grant[1])) begin
            lock_active <= 1'b0;
         end
      end
   end
`else
   assign lock_active = 1'b0;
   assign lock_owner  = 1'b0;

   logic unused_lock;
   assign unused_lock = ^req_lock;
`endif

   // ------------------------------------------------------------------------
   // Grant: port 0 has priority unless port 1 has waited MAX_WAIT cycles.
   // Reset also forces req_ready low so nothing is accepted while in reset.
   // ------------------------------------------------------------------------
   // NOTE: every signal written in an always_comb gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant = 2'b00;
      if (rst_n && !stall) begin
         if (lock_active) begin
            if (lock_owner) grant[1] = req_valid[1];
            else            grant[0] = req_valid[0];
         end else if ((starve_cnt == MAX_WAIT_C) && req_valid[1]) begin
            grant = 2'b10;
         end else if (req_valid[0]) begin
            grant = 2'b01;
         end else if (req_valid[1]) begin
            grant = 2'b10;
         end
      end
   end

   assign req_ready = grant;

   // ------------------------------------------------------------------------
   // Starvation counter (saturating). Frozen during stall and while locked.
   // ------------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= 4'd0;
      end else if (!stall && !lock_active) begin
         if (grant[1] || !req_valid[1]) begin
            starve_cnt <= 4'd0;
         end else if (starve_cnt != 4'hF) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Issue stage: loads the granted op, or zeroes itself when nothing is
   // granted so the ALU sees op 0 and zero operands while idle.
   // ------------------------------------------------------------------------
   always_comb begin
      sel_op = '0;
      sel_s1 = '0;
      sel_s2 = '0;
      if (grant[1]) begin
         sel_op = req1_op;
         sel_s1 = req1_s1;
         sel_s2 = req1_s2;
      end else if (grant[0]) begin
         sel_op = req0_op;
         sel_s1 = req0_s1;
         sel_s2 = req0_s2;
      end
   end

   // NOTE: every flop here is reset; issue and response contents must be
   // discarded on reset so no stale op produces a response pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_valid <= 1'b0;
         issue_owner <= 1'b0;
         issue_op    <= '0;
         issue_s1    <= '0;
         issue_s2    <= '0;
      end else if (!stall) begin
         issue_valid <= |grant;
         issue_owner <= grant[1];
         issue_op    <= sel_op;
         issue_s1    <= sel_s1;
         issue_s2    <= sel_s2;
      end
   end

   assign alu_op = issue_op;
   assign alu_s1 = issue_s1;
   assign alu_s2 = issue_s2;

   // ------------------------------------------------------------------------
   // Response stage: captures the ALU outputs for a valid issue op on a
   // non-stall cycle. During stall the pulse is suppressed and the payload
   // held; the op is still in the issue stage and is reported once the stall
   // drops. An unrecognised op reports rsp_err with zero data and no branch.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 2'b00;
         rsp_data   <= '0;
         rsp_branch <= 1'b0;
         rsp_err    <= 1'b0;
      end else if (stall) begin
         rsp_valid  <= 2'b00;
      end else if (issue_valid) begin
         rsp_valid  <= issue_owner ? 2'b10 : 2'b01;
         rsp_data   <= alu_ic_en ? alu_result : '0;
         rsp_branch <= alu_ic_en & alu_branch_flag;
         rsp_err    <= ~alu_ic_en;
      end else begin
         rsp_valid  <= 2'b00;
      end
   end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_arbiter
//
// Directed bench for alu_issue_arbiter with a small behavioural ALU:
//   op 1 ADD, op 2 SUB, op 3 BEQ (result 0, branch = s1==s2),
//   any other op unrecognised (ic_en=0, garbage result 0xDEAD).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// 1 time unit later, well away from the next rising edge.
// The lock sequence is exercised only when ALU_ARB_LOCK_EN is defined.
// ---------------------------------------------------------------------------
module tb_alu_issue_arbiter;

   localparam int OP_W   = 5;
   localparam int DATA_W = 64;

   localparam logic [OP_W-1:0] OP_ADD = 5'd1;
   localparam logic [OP_W-1:0] OP_SUB = 5'd2;
   localparam logic [OP_W-1:0] OP_BEQ = 5'd3;
   localparam logic [OP_W-1:0] OP_BAD = 5'd31;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              stall;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0]        req_lock;
   logic [OP_W-1:0]   req0_op, req1_op;
   logic [DATA_W-1:0] req0_s1, req0_s2, req1_s1, req1_s2;
   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_s1, alu_s2;
   logic [DATA_W-1:0] alu_result;
   logic              alu_branch_flag;
   logic              alu_ic_en;
   logic [1:0]        rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_branch;
   logic              rsp_err;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_issue_arbiter #(.OP_W(OP_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
      .req0_op(req0_op), .req0_s1(req0_s1), .req0_s2(req0_s2),
      .req1_op(req1_op), .req1_s1(req1_s1), .req1_s2(req1_s2),
      .alu_op(alu_op), .alu_s1(alu_s1), .alu_s2(alu_s2),
      .alu_result(alu_result), .alu_branch_flag(alu_branch_flag),
      .alu_ic_en(alu_ic_en),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_branch(rsp_branch), .rsp_err(rsp_err)
   );

   // Behavioural ALU
   always_comb begin
      alu_result      = 64'h0;
      alu_branch_flag = 1'b0;
      alu_ic_en       = 1'b1;
      case (alu_op)
         OP_ADD:  alu_result = alu_s1 + alu_s2;
         OP_SUB:  alu_result = alu_s1 - alu_s2;
         OP_BEQ:  alu_branch_flag = (alu_s1 == alu_s2);
         default: begin
            alu_ic_en  = 1'b0;
            alu_result = 64'hDEAD;
         end
      endcase
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 2'b00;
      req_lock  = 2'b00;
      req0_op = '0; req0_s1 = '0; req0_s2 = '0;
      req1_op = '0; req1_s1 = '0; req1_s2 = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // ---------------- reset ----------------
      rst_n = 1'b0;
      stall = 1'b0;
      idle_inputs();
      req_valid = 2'b11;
      tick();
      #1;
      check("reset_ready",     64'(req_ready), 64'h0);
      check("reset_alu_op",    64'(alu_op),    64'h0);
      check("reset_alu_s1",    alu_s1,         64'h0);
      check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
      check("reset_rsp_data",  rsp_data,       64'h0);
      check("reset_rsp_err",   64'(rsp_err),   64'h0);
      req_valid = 2'b00;
      tick();
      rst_n = 1'b1;

      // ---------------- 1: single ADD on port 0 ----------------
      tick();
      req_valid = 2'b01; req0_op = OP_ADD; req0_s1 = 64'd5; req0_s2 = 64'd7;
      #1;
      check("t1_ready", 64'(req_ready), 64'h1);
      tick();
      idle_inputs();
      #1;
      check("t1_alu_op",    64'(alu_op),    64'(OP_ADD));
      check("t1_alu_s1",    alu_s1,         64'd5);
      check("t1_alu_s2",    alu_s2,         64'd7);
      check("t1_rsp_early", 64'(rsp_valid), 64'h0);
      tick();
      #1;
      check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
      check("t1_rsp_data",  rsp_data,       64'd12);
      check("t1_rsp_err",   64'(rsp_err),   64'h0);
      tick();
      #1;
      check("t1_rsp_done",  64'(rsp_valid), 64'h0);
      check("t1_alu_idle",  64'(alu_op),    64'h0);

      // ---------------- 2: starvation, both ports valid ----------------
      // Port 0 wins cycles 1..4, port 1 wins cycle 5, counter restarts so
      // port 0 wins cycle 6 again.
      for (int k = 1; k <= 6; k++) begin
         tick();
         req_valid = 2'b11;
         req0_op = OP_ADD; req0_s1 = 64'(k); req0_s2 = 64'd10;
         req1_op = OP_SUB; req1_s1 = 64'd100; req1_s2 = 64'd1;
         #1;
         check($sformatf("t2_ready_c%0d", k), 64'(req_ready), (k == 5) ? 64'h2 : 64'h1);
         if (k >= 3) begin
            check($sformatf("t2_rsp_valid_c%0d", k), 64'(rsp_valid), 64'h1);
            check($sformatf("t2_rsp_data_c%0d", k),  rsp_data,       64'(k - 2 + 10));
         end
      end
      tick();
      idle_inputs();
      #1;
      check("t2_rsp_p1_valid", 64'(rsp_valid), 64'h2);
      check("t2_rsp_p1_data",  rsp_data,       64'd99);
      tick();
      #1;
      check("t2_rsp_last_valid", 64'(rsp_valid), 64'h1);
      check("t2_rsp_last_data",  rsp_data,       64'd16);
      tick();
      #1;
      check("t2_rsp_idle", 64'(rsp_valid), 64'h0);

      // ---------------- 3: stall holds the issue stage ----------------
      tick();
      req_valid = 2'b01; req0_op = OP_SUB; req0_s1 = 64'd50; req0_s2 = 64'd8;
      #1;
      check("t3_ready", 64'(req_ready), 64'h1);
      for (int k = 1; k <= 3; k++) begin
         tick();
         idle_inputs();
         stall = 1'b1;
         if (k == 2) begin
            req_valid = 2'b10; req1_op = OP_ADD;
         end
         #1;
         check($sformatf("t3_alu_op_s%0d", k), 64'(alu_op),    64'(OP_SUB));
         check($sformatf("t3_alu_s1_s%0d", k), alu_s1,         64'd50);
         check($sformatf("t3_rsp_s%0d", k),    64'(rsp_valid), 64'h0);
         check($sformatf("t3_ready_s%0d", k),  64'(req_ready), 64'h0);
      end
      // First non-stall cycle: op still in issue stage, response loads at its end.
      tick();
      idle_inputs();
      stall = 1'b0;
      #1;
      check("t3_alu_op_release", 64'(alu_op),    64'(OP_SUB));
      check("t3_rsp_release",    64'(rsp_valid), 64'h0);
      tick();
      #1;
      check("t3_rsp_valid", 64'(rsp_valid), 64'h1);
      check("t3_rsp_data",  rsp_data,       64'd42);
      tick();
      #1;
      check("t3_rsp_once",  64'(rsp_valid), 64'h0);

      // ---------------- 4: unrecognised op on port 1, then BEQ on port 0 ----------------
      tick();
      req_valid = 2'b10; req1_op = OP_BAD; req1_s1 = 64'd3; req1_s2 = 64'd4;
      #1;
      check("t4_ready_p1", 64'(req_ready), 64'h2);
      tick();
      idle_inputs();
      req_valid = 2'b01; req0_op = OP_BEQ; req0_s1 = 64'd9; req0_s2 = 64'd9;
      #1;
      check("t4_ready_p0", 64'(req_ready), 64'h1);
      check("t4_alu_op",   64'(alu_op),    64'(OP_BAD));
      tick();
      idle_inputs();
      #1;
      check("t4_err_valid",  64'(rsp_valid),  64'h2);
      check("t4_err_flag",   64'(rsp_err),    64'h1);
      check("t4_err_data",   rsp_data,        64'h0);
      check("t4_err_branch", 64'(rsp_branch), 64'h0);
      tick();
      #1;
      check("t4_beq_valid",  64'(rsp_valid),  64'h1);
      check("t4_beq_branch", 64'(rsp_branch), 64'h1);
      check("t4_beq_err",    64'(rsp_err),    64'h0);
      check("t4_beq_data",   rsp_data,        64'h0);

      // ---------------- 6: reset the cycle after an accept ----------------
      tick();
      req_valid = 2'b01; req0_op = OP_ADD; req0_s1 = 64'd20; req0_s2 = 64'd22;
      #1;
      check("t6_ready", 64'(req_ready), 64'h1);
      tick();
      idle_inputs();
      rst_n = 1'b0;
      #1;
      check("t6_alu_op_rst",  64'(alu_op),    64'h0);
      check("t6_rsp_rst",     64'(rsp_valid), 64'h0);
      tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         tick();
         check($sformatf("t6_rsp_valid_%0d", k), 64'(rsp_valid), 64'h0);
         check($sformatf("t6_rsp_data_%0d", k),  rsp_data,       64'h0);
         check($sformatf("t6_alu_op_%0d", k),    64'(alu_op),    64'h0);
         check($sformatf("t6_rsp_err_%0d", k),   64'(rsp_err),   64'h0);
      end

`ifdef ALU_ARB_LOCK_EN
      // ---------------- 5: port 1 lock sequence ----------------
      // Port 1 is first granted on starvation (cycle 5) with lock=1, keeps
      // the grant with lock=1 (cycle 6) and lock=0 (cycle 7); port 0 follows.
      for (int k = 1; k <= 8; k++) begin
         tick();
         req_valid = 2'b11;
         req_lock  = (k <= 6) ? 2'b10 : 2'b00;
         req0_op = OP_ADD; req0_s1 = 64'd1; req0_s2 = 64'd1;
         req1_op = OP_ADD; req1_s1 = 64'(k); req1_s2 = 64'd0;
         #1;
         check($sformatf("t5_ready_c%0d", k), 64'(req_ready),
               ((k >= 5) && (k <= 7)) ? 64'h2 : 64'h1);
      end
      tick();
      idle_inputs();
`endif

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
